// File: rtl/fp_mult_pkg.sv
// Shared constants and stage payload for the FP multiplier normalize/round back end.
// Exponents are carried as 11-bit signed so in_exp+1 and the rounding carry never wrap.
package fp_mult_pkg;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_INF  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam int          EXP_W    = 11;

    typedef struct packed {
        logic                    sign;
        logic                    nan;
        logic                    inf;
        logic                    zero;
        logic signed [EXP_W-1:0] exp;
        logic [22:0]             frac;
        logic                    guard;
        logic                    sticky;
    } s1_payload_t;

    // Align the 48-bit product so the hidden one sits just above frac.
    function automatic s1_payload_t normalize(input logic        sign,
                                              input logic        nan,
                                              input logic        inf,
                                              input logic        zero,
                                              input logic [9:0]  exp,
                                              input logic [47:0] mant);
        s1_payload_t             p;
        logic signed [EXP_W-1:0] exp_ext;
        exp_ext = {exp[9], exp};
        p.sign  = sign;
        p.nan   = nan;
        p.inf   = inf;
        p.zero  = zero;
        if (mant[47]) begin
            p.frac   = mant[46:24];
            p.guard  = mant[23];
            p.sticky = |mant[22:0];
            p.exp    = exp_ext + 11'sd1;
        end else begin
            p.frac   = mant[45:23];
            p.guard  = mant[22];
            p.sticky = |mant[21:0];
            p.exp    = exp_ext;
        end
        return p;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction; a carry out of the fraction
// wraps it to zero and bumps the exponent.
module fp_round_rne
    import fp_mult_pkg::*;
(
    input  logic [22:0]             frac_i,
    input  logic                    guard_i,
    input  logic                    sticky_i,
    input  logic signed [EXP_W-1:0] exp_i,
    output logic [22:0]             frac_o,
    output logic signed [EXP_W-1:0] exp_o
);

    logic        inc;
    logic [23:0] sum;

    assign inc    = guard_i & (sticky_i | frac_i[0]);
    assign sum    = {1'b0, frac_i} + {23'd0, inc};
    assign frac_o = sum[22:0];
    assign exp_o  = exp_i + $signed({{(EXP_W-1){1'b0}}, sum[23]});

endmodule

// File: rtl/fp_mult_norm_round.sv
// Two-stage back end of an FP32 multiplier: S1 normalizes the raw product,
// S2 rounds, applies overflow/underflow/special cases and holds the packed result.
module fp_mult_norm_round
    import fp_mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic        out_unf
);

    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(EXP_INF);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;

    logic                    s1_valid_q;
    s1_payload_t             s1_q;
    s1_payload_t             s1_d;
    logic                    s2_valid_q;
    logic [31:0]             res_q, res_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    s1_adv, s2_adv;
    logic [22:0]             rnd_frac;
    logic signed [EXP_W-1:0] rnd_exp;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign s1_d = normalize(in_sign, in_nan, in_inf, in_zero, in_exp, in_mant);

    fp_round_rne u_round (
        .frac_i   (s1_q.frac),
        .guard_i  (s1_q.guard),
        .sticky_i (s1_q.sticky),
        .exp_i    (s1_q.exp),
        .frac_o   (rnd_frac),
        .exp_o    (rnd_exp)
    );

    // Specials take priority and never raise ovf/unf.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (s1_q.nan) begin
            res_d = QNAN;
        end else if (s1_q.inf) begin
            res_d = {s1_q.sign, 8'hFF, 23'h0};
        end else if (s1_q.zero) begin
            res_d = {s1_q.sign, 31'h0};
        end else if (rnd_exp >= EXP_MAX) begin
            res_d = {s1_q.sign, 8'hFF, 23'h0};
            ovf_d = 1'b1;
        end else if (rnd_exp <= EXP_ZERO) begin
            res_d = {s1_q.sign, 31'h0};
            unf_d = 1'b1;
        end else begin
            res_d = {s1_q.sign, rnd_exp[7:0], rnd_frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (s1_adv && in_valid) s1_q <= s1_d;
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s2_adv && s1_valid_q) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;

endmodule

// File: tb/tb_fp_mult_norm_round.sv
// Scoreboard bench for fp_mult_norm_round: a driver pushes reference results on
// every accepted input, a monitor pops and compares on every output transfer.
module tb_fp_mult_norm_round;
    import fp_mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic        in_nan = 1'b0, in_inf = 1'b0, in_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_ovf, out_unf;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic        nan, inf, zero;
    } stim_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf, unf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled

    fp_mult_norm_round dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    // Reference: exact remainder comparison against half an ulp.
    function automatic exp_t model(input stim_t s);
        exp_t            r;
        int              e, sh;
        longint unsigned m, q, rem, half, f;
        r.res = '0; r.ovf = 1'b0; r.unf = 1'b0;
        if (s.nan)       begin r.res = QNAN; return r; end
        if (s.inf)       begin r.res = {s.sign, 8'hFF, 23'h0}; return r; end
        if (s.zero)      begin r.res = {s.sign, 31'h0}; return r; end
        e = int'($signed(s.exp));
        m = 64'(s.mant);
        if (s.mant[47]) begin sh = 24; e = e + 1; end else sh = 23;
        q    = m >> sh;
        rem  = m & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        f    = q % (64'd1 << 23);
        if (rem > half || (rem == half && f % 2 == 1)) f = f + 1;
        if (f == (64'd1 << 23)) begin f = 0; e = e + 1; end
        if (e >= EXP_INF)  begin r.res = {s.sign, 8'hFF, 23'h0}; r.ovf = 1'b1; end
        else if (e <= 0)   begin r.res = {s.sign, 31'h0};        r.unf = 1'b1; end
        else               r.res = {s.sign, 8'(e), 23'(f)};
        return r;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int    k;
        s.sign = 1'($urandom);
        s.mant = 48'({$urandom, $urandom});
        if ($urandom_range(0, 1) == 0) s.mant[47] = 1'b1;
        else begin s.mant[47] = 1'b0; s.mant[46] = 1'b1; end
        if ($urandom_range(0, 3) == 0) begin
            if (s.mant[47]) s.mant[22:0] = '0; else s.mant[21:0] = '0;
        end
        k = int'($urandom_range(0, 3));
        case (k)
            0:       s.exp = 10'($urandom_range(100, 160));
            1:       s.exp = 10'($urandom_range(245, 260));
            2:       s.exp = 10'($urandom_range(0, 10)) - 10'd5;
            default: s.exp = 10'($urandom);
        endcase
        k = int'($urandom_range(0, 19));
        s.nan  = (k == 0);
        s.inf  = (k == 1) || (k == 0 && $urandom_range(0, 1) == 1);
        s.zero = (k == 2);
        return s;
    endfunction

    function automatic stim_t mk(input logic sg, input logic [9:0] e, input logic [47:0] m,
                                 input logic n, input logic i, input logic z);
        stim_t s;
        s.sign = sg; s.exp = e; s.mant = m; s.nan = n; s.inf = i; s.zero = z;
        return s;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input stim_t s);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_sign = s.sign; in_exp = s.exp; in_mant = s.mant;
        in_nan = s.nan; in_inf = s.inf; in_zero = s.zero;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(s));
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 300 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin : ready_driver
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        logic        stall_seen;
        logic [33:0] stall_val;
        exp_t        e;
        stall_seen = 1'b0;
        stall_val  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_seen = 1'b0;
            end else begin
                if (stall_seen) begin
                    checks++;
                    if (!out_valid || {out_ovf, out_unf, out_result} != stall_val) begin
                        errors++;
                        $display("FAIL hold: got v=%0b %h, required v=1 %h",
                                 out_valid, {out_ovf, out_unf, out_result}, stall_val);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h, required no output", out_result);
                    end else begin
                        e = sb_q.pop_front();
                        if (out_result !== e.res || out_ovf !== e.ovf || out_unf !== e.unf) begin
                            errors++;
                            $display("FAIL result: got %h ovf=%0b unf=%0b, required %h ovf=%0b unf=%0b",
                                     out_result, out_ovf, out_unf, e.res, e.ovf, e.unf);
                        end else begin
                            $display("out %h ovf=%0b unf=%0b ok", out_result, out_ovf, out_unf);
                        end
                    end
                end
                stall_seen = out_valid && !out_ready;
                stall_val  = {out_ovf, out_unf, out_result};
            end
        end
    end

    initial begin : stimulus
        stim_t dir[$];

        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b %h %0b%0b, required v=0 0 00",
                     out_valid, out_result, out_ovf, out_unf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %0b, required 1", in_ready);
        end
        @(posedge clk); #1;

        // Directed corner vectors
        dir.push_back(mk(1'b0, 10'(EXP_BIAS), 48'h9000_0000_0000, 0, 0, 0));
        dir.push_back(mk(1'b0, 10'(EXP_BIAS), 48'h4000_0040_0000, 0, 0, 0));
        dir.push_back(mk(1'b0, 10'(EXP_BIAS), 48'h4000_00C0_0000, 0, 0, 0));
        dir.push_back(mk(1'b0, 10'(EXP_BIAS), 48'h7FFF_FFC0_0000, 0, 0, 0));
        dir.push_back(mk(1'b0, 10'd254,       48'h8000_0000_0000, 0, 0, 0));
        dir.push_back(mk(1'b1, 10'd0,         48'h4000_0000_0000, 0, 0, 0));
        dir.push_back(mk(1'b0, 10'd5,         48'h4000_0000_0000, 1, 1, 0));
        dir.push_back(mk(1'b1, 10'd5,         48'h4000_0000_0000, 0, 1, 0));
        dir.push_back(mk(1'b1, 10'd5,         48'h4000_0000_0000, 0, 0, 1));
        rdy_mode = 1;
        foreach (dir[i]) send(dir[i]);
        drain();

        // Backpressure: 4 back-to-back with out_ready low for 3 cycles
        rdy_mode = 2;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 4; i++) send(rand_stim());
            end
            begin
                repeat (3) @(negedge clk);
                checks++;
                if (in_ready !== 1'b0 || sb_q.size() != 2) begin
                    errors++;
                    $display("FAIL backpressure: got in_ready=%0b accepted=%0d, required 0 and 2",
                             in_ready, sb_q.size());
                end
                rdy_mode = 1;
            end
        join
        drain();

        // Randomized traffic with random downstream stalls
        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            send(rand_stim());
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end
        drain();

        // Reset with both stages full
        rdy_mode = 2;
        @(posedge clk); #1;
        send(rand_stim());
        send(rand_stim());
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b %h %0b%0b, required v=0 0 00",
                     out_valid, out_result, out_ovf, out_unf);
        end
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 1;
        @(posedge clk); #1;
        send(mk(1'b0, 10'(EXP_BIAS), 48'h9000_0000_0000, 0, 0, 0));
        drain();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_norm_round.md
FP_MULT_NORM_ROUND -- requirements
Module: fp_mult_norm_round

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, upstream product/exponent valid.
REQ-004 SHALL have port in_ready, output, 1, block can accept an input this cycle.
REQ-005 SHALL have port in_sign, input, 1, result sign (sa XOR sb).
REQ-006 SHALL have port in_exp, input, 10, signed two's-complement biased exponent ea+eb-127, pre-normalization.
REQ-007 SHALL have port in_mant, input, 48, unsigned 24x24 mantissa product (hidden bits included).
REQ-008 SHALL have port in_nan, in_inf, in_zero, input, 1 each, special-case flags from the unpack stage.
REQ-009 SHALL have port out_valid, input-to-output handshake, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port out_result, output, 32, IEEE-754 single result.
REQ-012 SHALL have port out_ovf and out_unf, output, 1 each, overflow / underflow flags aligned with out_result.

Function
REQ-013 SHALL be a two-stage pipeline: S1 normalize, S2 round and pack; latency 2 cycles from accepted input to out_valid with out_ready held high.
REQ-014 SHALL transfer on a side only when valid and ready are both high in the same cycle.
REQ-015 S1 SHALL advance when S1 empty or S2 advances; S2 advances when S2 empty or out_ready=1; in_ready = S1 advances (combinational from out_ready allowed).
REQ-016 S1 normalize: if in_mant[47]=1 then frac=in_mant[46:24], guard=in_mant[23], sticky=OR(in_mant[22:0]), exp=in_exp+1; else frac=in_mant[45:23], guard=in_mant[22], sticky=OR(in_mant[21:0]), exp=in_exp.
REQ-017 S2 SHALL round to nearest even: increment frac when guard=1 AND (sticky=1 OR frac[0]=1).
REQ-018 On frac increment carry-out (frac was all ones), frac SHALL become 0 and exp SHALL increase by 1.
REQ-019 Post-round exp >= 255 (signed) SHALL yield {sign,8'hFF,23'h0}, out_ovf=1.
REQ-020 Post-round exp <= 0 (signed) SHALL yield {sign,31'h0}, out_unf=1 (denormals flushed to zero).
REQ-021 Special priority nan > inf > zero > normal: nan -> 32'h7FC00000; inf -> {sign,8'hFF,23'h0}; zero -> {sign,31'h0}; ovf/unf = 0 for specials.
REQ-022 Stage data SHALL hold stable while its valid is high and it cannot advance; no input lost or duplicated under backpressure.
REQ-023 Simultaneous S2 drain and S1 refill in one cycle SHALL sustain throughput of one result per cycle.

Reset
REQ-024 rst_n low SHALL immediately clear both stage valids; out_valid=0, out_result=0, out_ovf=0, out_unf=0.
REQ-025 Reset mid-operation SHALL discard in-flight data; first accepted input after release produces the first output.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release when out_ready is irrelevant (pipeline empty).

Structure
REQ-027 Constants EXP_BIAS=127, EXP_INF=255, QNAN=32'h7FC00000 and the stage payload record SHALL live in shared package fp_mult_pkg.
REQ-028 Rounding (REQ-017/018) SHALL be one sub-module fp_round_rne (inputs frac, guard, sticky, exp; outputs frac, exp), combinational.

Verification
REQ-029 in_exp=127, in_mant=48'h900000000000, sign=0 -> out_result=32'h40100000 (2.25) two cycles later, ovf=unf=0.
REQ-030 in_exp=127, in_mant bit47=0, frac lsb=0, guard=1, sticky=0 -> no increment; same with lsb=1 -> frac+1.
REQ-031 in_exp=254, in_mant[47]=1 -> 32'h7F800000, out_ovf=1; in_exp=0, in_mant[47]=0, sign=1 -> 32'h80000000, out_unf=1.
REQ-032 in_nan=1 with in_inf=1 -> 32'h7FC00000; in_inf=1 sign=1 -> 32'hFF800000.
REQ-033 Push 4 back-to-back inputs, out_ready low 3 cycles -> in_ready low after 2 accepted, outputs held, all 4 emerge in order once out_ready=1.
REQ-034 Assert rst_n low with both stages full -> out_valid=0 same cycle; no stale result after release.
